// File: rtl/sbox_gen_lut.sv
// S-box table builder: keeps first occurrences of a sample stream to build a forward permutation
// and its inverse, then serves single-cycle forward/inverse lookups until cleared or reset.
module sbox_gen_lut #(
    parameter int unsigned BIT_WIDTH = 8,
    parameter int unsigned DUP_W     = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 clear,
    input  logic                 tvalid,
    input  logic [BIT_WIDTH-1:0] V,
    output logic                 tready,
    output logic                 acc_valid,
    output logic [BIT_WIDTH-1:0] acc_data,
    output logic                 rej_valid,
    output logic [DUP_W-1:0]     dup_cnt,
    output logic [BIT_WIDTH:0]   count,
    output logic                 done,
    output logic                 lut_ready,
    input  logic                 lk_valid,
    input  logic                 lk_inv,
    input  logic [BIT_WIDTH-1:0] lk_addr,
    output logic                 lk_out_valid,
    output logic [BIT_WIDTH-1:0] lk_out,
    output logic                 lk_err
);
    localparam int unsigned SIZE = 1 << BIT_WIDTH;

    typedef enum logic {StBuild, StReady} state_e;
    state_e state_q, state_d;

    logic [SIZE-1:0]      used_q;
    logic [BIT_WIDTH-1:0] fwd_q [SIZE];
    logic [BIT_WIDTH-1:0] inv_q [SIZE];
    logic [BIT_WIDTH:0]   count_q;
    logic [DUP_W-1:0]     dup_q;
    logic [BIT_WIDTH-1:0] acc_data_q, lk_out_q;
    logic                 acc_valid_q, rej_valid_q, done_q, lk_out_valid_q, lk_err_q;

    logic accept, reject, last, lk_hit, lk_miss;

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        reject  = 1'b0;
        lk_hit  = 1'b0;
        lk_miss = 1'b0;
        last    = (count_q == (BIT_WIDTH + 1)'(SIZE - 1));
        // clear wins over samples and lookups arriving in the same cycle
        if (clear) begin
            state_d = StBuild;
        end else begin
            unique case (state_q)
                StBuild: begin
                    if (tvalid) begin
                        accept = !used_q[V];
                        reject = used_q[V];
                    end
                    if (accept && last) state_d = StReady;
                    lk_miss = lk_valid;
                end
                StReady: lk_hit = lk_valid;
                default: state_d = StBuild;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= StBuild;
            used_q         <= '0;
            count_q        <= '0;
            dup_q          <= '0;
            acc_valid_q    <= 1'b0;
            acc_data_q     <= '0;
            rej_valid_q    <= 1'b0;
            done_q         <= 1'b0;
            lk_out_valid_q <= 1'b0;
            lk_out_q       <= '0;
            lk_err_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            acc_valid_q    <= accept;
            rej_valid_q    <= reject;
            done_q         <= accept && last;
            lk_out_valid_q <= lk_hit;
            lk_err_q       <= lk_miss;
            if (accept) acc_data_q <= V;
            if (lk_hit) lk_out_q <= lk_inv ? inv_q[lk_addr] : fwd_q[lk_addr];
            if (clear) begin
                used_q  <= '0;
                count_q <= '0;
                dup_q   <= '0;
            end else begin
                if (accept) begin
                    used_q[V] <= 1'b1;
                    count_q   <= count_q + 1'b1;
                end
                if (reject && (dup_q != '1)) dup_q <= dup_q + 1'b1;
            end
        end
    end

    // Table storage is not reset; the used bits alone decide what is valid.
    always_ff @(posedge clk) begin
        if (accept) begin
            fwd_q[count_q[BIT_WIDTH-1:0]] <= V;
            inv_q[V]                      <= count_q[BIT_WIDTH-1:0];
        end
    end

    assign tready       = (state_q == StBuild);
    assign lut_ready    = (state_q == StReady);
    assign acc_valid    = acc_valid_q;
    assign acc_data     = acc_data_q;
    assign rej_valid    = rej_valid_q;
    assign dup_cnt      = dup_q;
    assign count        = count_q;
    assign done         = done_q;
    assign lk_out_valid = lk_out_valid_q;
    assign lk_out       = lk_out_q;
    assign lk_err       = lk_err_q;

endmodule

// File: doc/sbox_gen_lut.md
# sbox_gen_lut

Parametrised successor to the byte S-box collector. Consumes the chaotic-map sample stream and keeps only first occurrences, building a forward S-box permutation of 2^BIT_WIDTH entries and, at the same time, its inverse table. Once complete, it serves single-cycle forward or inverse substitution lookups to the encryption and decryption datapaths. It also supports a synchronous restart so a new key/map can rebuild the tables without a global reset.

## Interface
- BIT_WIDTH, 8, symbol width; table depth SIZE = 2^BIT_WIDTH (derived, not overridable); legal range 2..10.
- DUP_W, 16, width of the saturating duplicate counter.

- clk  in  1  single clock, all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous restart request.
- tvalid  in  1  input sample valid.
- V  in  BIT_WIDTH  input sample.
- tready  out  1  high when samples are consumed (BUILD state).
- acc_valid  out  1  one-cycle pulse: sample accepted.
- acc_data  out  BIT_WIDTH  last accepted sample.
- rej_valid  out  1  one-cycle pulse: sample rejected as duplicate.
- dup_cnt  out  DUP_W  duplicates seen, saturating.
- count  out  BIT_WIDTH+1  entries filled, 0..SIZE.
- done  out  1  one-cycle pulse on completion.
- lut_ready  out  1  level, tables complete (READY state).
- lk_valid  in  1  lookup request.
- lk_inv  in  1  0 = forward, 1 = inverse table.
- lk_addr  in  BIT_WIDTH  lookup index.
- lk_out_valid  out  1  lookup result valid.
- lk_out  out  BIT_WIDTH  lookup result.
- lk_err  out  1  one-cycle pulse: lookup requested while not READY.

## Operation
- State machine with two states, BUILD and READY. Reset enters BUILD. tready = (state == BUILD), combinational.
- **BUILD, tvalid with used[V] = 0:**
  - Write fwd[count] = V, inv[V] = count, used[V] = 1.
  - acc_valid = 1, acc_data = V, count increments.
- **BUILD, tvalid with used[V] = 1:**
  - rej_valid = 1.
  - dup_cnt increments and holds at all-ones.
  - No table write; acc_data holds.
- **Completion:** when the accepted sample is the SIZE-th (count was SIZE-1):
  - done pulses in the same cycle as that acc_valid.
  - State goes to READY on that same edge; count = SIZE.
- **READY:**
  - tvalid is ignored: no acc, rej or counter change.
  - Lookup with lk_valid: the next cycle gives lk_out_valid = 1 and lk_out = lk_inv ? inv[lk_addr] : fwd[lk_addr].
  - Back-to-back lookups are allowed every cycle.
- **Lookup in BUILD:** lk_valid produces lk_err = 1 the next cycle. lk_out_valid stays 0 and lk_out holds.
- **clear (any state):** takes priority over tvalid and lk_valid in the same cycle.
  - Next cycle: state = BUILD, count = 0, dup_cnt = 0, all used bits = 0 (flash clear, one cycle), lut_ready = 0.
  - All pulse outputs are 0 that cycle; a sample presented with clear is dropped.
  - fwd/inv contents are don't-care until rewritten.
- Tables are register arrays. used, fwd and inv are not reset by reset_n beyond the used bits, which must clear.

## Timing
- **Reset values:** acc_valid 0, acc_data 0, rej_valid 0, dup_cnt 0, count 0, done 0, lut_ready 0, lk_out_valid 0, lk_out 0, lk_err 0, all used 0.
- tready reads 1 during reset (state = BUILD), but no sample is consumed while reset_n is low.
- Accept/reject decision and outputs: one cycle after the sample edge. Throughput is one sample per cycle.
- Lookup latency is exactly 1 cycle.
- **Reset asserted mid-BUILD or mid-READY:** immediate return to reset values and BUILD. Partial tables are discarded.

## Test plan
- **Basic build:** BIT_WIDTH=3; feed 3,3,7,0,1,2,4,5,6 back-to-back.
  - Expect 8 acc_valid pulses with acc_data 3,7,0,1,2,4,5,6.
  - Expect one rej_valid, on the second 3, and dup_cnt=1.
  - done coincides with acc of 6; count=8; lut_ready=1 next cycle.
- **Lookups:** after the build above:
  - fwd[0] gives 3; fwd[7] gives 6; inv[7] gives 1; inv[3] gives 0.
  - Sweep all 8 addresses both ways: inv[fwd[x]] = x.
  - Each result arrives 1 cycle after request, including back-to-back requests.
- **Input in READY:** tvalid=1, V=0 → tready=0, no acc_valid or rej_valid, count stays 8.
- **Early lookup:** lk_valid during BUILD after 2 accepts → lk_err pulse, lk_out_valid=0.
- **Clear mid-build:** after accepting 3,7,0,1, assert clear with tvalid=1, V=2.
  - Next cycle: count=0, dup_cnt=0, no acc_valid.
  - Then feed 3 → accepted (used cleared).
- **Reset and full size:** BIT_WIDTH=8 with an LFSR stream.
  - Exactly 256 accepts; fwd is a permutation; inverse check passes; dup_cnt matches the scoreboard.
  - Pulse reset_n in READY → all outputs at reset values, tready=1, then a full rebuild succeeds.
